// File: rtl/alu_pkg.sv
// Shared ALU control encoding, multiplier FSM states and opcode class helpers.
package alu_pkg;

    localparam int unsigned ALU_XLEN   = 32;
    localparam int unsigned ALU_CTRL_W = 5;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'h00, ALU_SUB    = 5'h01, ALU_SLL    = 5'h02, ALU_SLT    = 5'h03,
        ALU_SLTU   = 5'h04, ALU_XOR    = 5'h05, ALU_SRL    = 5'h06, ALU_SRA    = 5'h07,
        ALU_OR     = 5'h08, ALU_AND    = 5'h09, ALU_BEQ    = 5'h0A, ALU_BNE    = 5'h0B,
        ALU_BLT    = 5'h0C, ALU_BGE    = 5'h0D, ALU_BLTU   = 5'h0E, ALU_BGEU   = 5'h0F,
        ALU_JALR   = 5'h10, ALU_IMM    = 5'h11, ALU_MUL    = 5'h12, ALU_MULH   = 5'h13,
        ALU_MULHSU = 5'h14, ALU_MULHU  = 5'h15, ALU_CsrRW  = 5'h16, ALU_CsrRS  = 5'h17,
        ALU_CsrRC  = 5'h18, ALU_CsrRWI = 5'h19, ALU_CsrRSI = 5'h1A, ALU_CsrRCI = 5'h1B
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} mul_state_e;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_MULHU);
    endfunction

    function automatic logic is_branch_op(input logic [4:0] op);
        return (op >= ALU_BEQ) && (op <= ALU_BGEU);
    endfunction

endpackage

// File: rtl/alu_exec_mul_iter.sv
// Iterative shift-add multiplier on operand magnitudes, one multiplier bit per cycle,
// followed by a single sign-fix cycle. Product is held in DONE until acknowledged.
module alu_exec_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = ALU_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
    input  logic              ack,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] prod
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    mul_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic              neg;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    assign a_neg = a_signed & a[XLEN-1];
    assign b_neg = b_signed & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{XLEN{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= a_neg ^ b_neg;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    // counter only returns to zero on leaving MUL
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (neg) acc <= -acc;
                    state <= DONE;
                end
                DONE: begin
                    if (ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign prod = acc;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle datapath with a registered result, plus an iterative
// multiplier for the MUL family, behind valid/ready handshakes on both sides.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = ALU_XLEN,
    parameter int unsigned CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              branch_taken,
    output logic              illegal_op
);

    logic              accept, start_mul, mul_busy, mul_done;
    logic              a_signed, b_signed;
    logic [2*XLEN-1:0] mul_prod;

    logic [XLEN-1:0]   sum, diff, calc_result;
    logic [4:0]        shamt;
    logic              lt_s, lt_u, eq, cond, calc_illegal;

    logic              out_valid_q, taken_q, illegal_q, mul_hi_q;
    logic [XLEN-1:0]   result_q;

    assign in_ready  = !mul_busy && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && is_mul_op(alu_ctrl);
    assign a_signed  = (alu_ctrl == ALU_MUL) || (alu_ctrl == ALU_MULH) || (alu_ctrl == ALU_MULHSU);
    assign b_signed  = (alu_ctrl == ALU_MUL) || (alu_ctrl == ALU_MULH);

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[4:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;
    assign eq    = (op_a == op_b);

    always_comb begin
        calc_result  = '0;
        cond         = 1'b0;
        calc_illegal = 1'b0;
        case (alu_ctrl)
            ALU_ADD:  calc_result = sum;
            ALU_SUB:  calc_result = diff;
            ALU_SLL:  calc_result = op_a << shamt;
            ALU_SLT:  calc_result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: calc_result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  calc_result = op_a ^ op_b;
            ALU_SRL:  calc_result = op_a >> shamt;
            ALU_SRA:  calc_result = $signed(op_a) >>> shamt;
            ALU_OR:   calc_result = op_a | op_b;
            ALU_AND:  calc_result = op_a & op_b;
            ALU_BEQ:  cond = eq;
            ALU_BNE:  cond = !eq;
            ALU_BLT:  cond = lt_s;
            ALU_BGE:  cond = !lt_s;
            ALU_BLTU: cond = lt_u;
            ALU_BGEU: cond = !lt_u;
            ALU_JALR: calc_result = {sum[XLEN-1:1], 1'b0};
            ALU_IMM:  calc_result = op_b;
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: calc_result = '0;
            ALU_CsrRW, ALU_CsrRS, ALU_CsrRC,
            ALU_CsrRWI, ALU_CsrRSI, ALU_CsrRCI: calc_result = op_a;
            default:  calc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            mul_hi_q    <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            if (is_mul_op(alu_ctrl)) begin
                // multiplier owns the output until its result leaves
                out_valid_q <= 1'b0;
                taken_q     <= 1'b0;
                illegal_q   <= 1'b0;
                mul_hi_q    <= (alu_ctrl != ALU_MUL);
            end else begin
                out_valid_q <= 1'b1;
                result_q    <= calc_result;
                taken_q     <= is_branch_op(alu_ctrl) && cond;
                illegal_q   <= calc_illegal;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    alu_exec_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .start    (start_mul),
        .ack      (out_ready),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .a        (op_a),
        .b        (op_b),
        .busy     (mul_busy),
        .done     (mul_done),
        .prod     (mul_prod)
    );

    assign out_valid    = out_valid_q || mul_done;
    assign result       = !mul_done ? result_q :
                          (mul_hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0]);
    assign branch_taken = taken_q;
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: expected results are queued at issue and checked as they
// leave the output port; timing, backpressure, flush and reset are checked inline.
module tb_alu_exec;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic        branch_taken, illegal_op;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a, op_b, result;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        taken;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_exec #(
        .XLEN   (32),
        .CTRL_W (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_ctrl     (alu_ctrl),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal_op   (illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op and wait for it to be accepted; queue its expectation if asked.
    task automatic send(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic et,
                        input logic ei, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        alu_ctrl = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            if (push) begin
                e.tag   = tag;
                e.res   = er;
                e.taken = et;
                e.ill   = ei;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.tag, "_result"}, result, e.res);
                chk({e.tag, "_taken"}, 32'(branch_taken), 32'(e.taken));
                chk({e.tag, "_illegal"}, 32'(illegal_op), 32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad, hold_bad;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = 5'h00; op_a = '0; op_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_taken", 32'(branch_taken), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // single-cycle ops, first with latency check
        send("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("add_latency_valid", 32'(out_valid), 32'd1);
        send("sub", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1);
        send("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
        send("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        send("sll0", ALU_SLL, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        send("srl", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 1'b1);
        send("xor", ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0, 1'b1);
        send("and", ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1'b1);
        send("blt", ALU_BLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1);
        send("bltu", ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        send("beq", ALU_BEQ, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
        send("bne", ALU_BNE, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
        send("bge", ALU_BGE, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        send("bgeu", ALU_BGEU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1);
        send("jalr", ALU_JALR, 32'h0000_1001, 32'd4, 32'h0000_1004, 1'b0, 1'b0, 1'b1);
        send("imm", ALU_IMM, 32'd9, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0, 1'b0, 1'b1);
        send("csr", ALU_CsrRC, 32'h0000_DEAD, 32'd1, 32'h0000_DEAD, 1'b0, 1'b0, 1'b1);
        send("ill1c", 5'h1C, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1);
        send("ill1f", 5'h1F, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1);

        // multiplier latency and busy window
        send("mul", ALU_MUL, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        lat = 0;
        bad = 0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) bad++;
        end while (!out_valid && lat < 60);
        chk("mul_latency", 32'(lat), 32'd34);
        chk("mul_busy_ready", 32'(bad), 32'd0);

        send("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        send("mulh_min", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        send("mul_neg", ALU_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b1);
        send("mulh_neg", ALU_MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send("mulhsu_pos", ALU_MULHSU, 32'd2, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b1);
        send("add_after_mul", ALU_ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b1);

        // backpressure: result held, no new op accepted
        repeat (40) @(negedge clk);
        out_ready = 1'b0;
        send("bp_add", ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1);
        alu_ctrl = ALU_SUB; op_a = 32'd10; op_b = 32'd3; in_valid = 1'b1;
        hold_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || result !== 32'd3 || in_ready) hold_bad++;
        end
        chk("bp_hold", 32'(hold_bad), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send("bp_sub", ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b1);

        // flush in the middle of a multiply
        repeat (3) @(negedge clk);
        send("mul_flushed", ALU_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        alu_ctrl = ALU_ADD; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        bad = 0;
        repeat (40) begin
            if (out_valid) bad++;
            @(negedge clk);
        end
        chk("flush_no_output", 32'(bad), 32'd0);

        // reset in the middle of a multiply
        send("pre_rst_add", ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b1);
        send("mul_reset", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_taken", 32'(branch_taken), 32'd0);
        chk("midrst_illegal", 32'(illegal_op), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("midrst_no_output", 32'(bad), 32'd0);
        send("post_rst_add", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
